barrel_shifter_right_pipe: RTL



---
 rtl/barrel_pkg.sv | 12 +
 rtl/shift_stage_right.sv | 82 ++++++++
 rtl/barrel_shifter_right_pipe.sv | 72 +++++++
 3 files changed

// File: rtl/barrel_pkg.sv
// Shared definitions for the right barrel shifter pipeline.
package barrel_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_LSR = 2'b00;
  localparam mode_t MODE_ASR = 2'b01;
  localparam mode_t MODE_ROR = 2'b10;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/shift_stage_right.sv
// One registered stage of the right barrel shifter: shifts by SHIFT when its select bit is set,
// accumulates the sticky flag and forwards the beat's side information to the next stage.
module shift_stage_right
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned SHIFT = 1,
  localparam int unsigned SHW = $clog2(WIDTH),
  localparam int unsigned IDX = $clog2(SHIFT)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   sel_i,
  input  mode_t            mode_i,
  input  logic             fill_i,
  input  logic             sticky_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   sel_o,
  output mode_t            mode_o,
  output logic             fill_o,
  output logic             sticky_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             sticky_d, sticky_q;
  logic [SHW-1:0]   sel_q;
  mode_t            mode_q;
  logic             fill_q, valid_q;
  logic             lost;

  // Shift by SHIFT according to mode; collect bits falling off the LSB end.
  always_comb begin
    data_d = data_i;
    lost   = 1'b0;
    if (sel_i[IDX]) begin
      case (mode_i)
        MODE_ROR: data_d = {data_i[SHIFT-1:0], data_i[WIDTH-1:SHIFT]};
        MODE_ASR: begin
          data_d = {{SHIFT{fill_i}}, data_i[WIDTH-1:SHIFT]};
          lost   = |data_i[SHIFT-1:0];
        end
        default: begin
          // Reserved mode encoding behaves as logical right.
          data_d = {{SHIFT{1'b0}}, data_i[WIDTH-1:SHIFT]};
          lost   = |data_i[SHIFT-1:0];
        end
      endcase
    end
    sticky_d = (mode_i == MODE_ROR) ? 1'b0 : (sticky_i | lost);
  end

  // Stage register; holds everything while the pipeline is stalled.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q   <= '0;
      sel_q    <= '0;
      mode_q   <= MODE_LSR;
      fill_q   <= 1'b0;
      sticky_q <= 1'b0;
      valid_q  <= 1'b0;
    end else if (en_i) begin
      data_q   <= data_d;
      sel_q    <= sel_i;
      mode_q   <= mode_i;
      fill_q   <= fill_i;
      sticky_q <= sticky_d;
      valid_q  <= valid_i;
    end
  end

  assign data_o   = data_q;
  assign sel_o    = sel_q;
  assign mode_o   = mode_q;
  assign fill_o   = fill_q;
  assign sticky_o = sticky_q;
  assign valid_o  = valid_q;

endmodule

// File: rtl/barrel_shifter_right_pipe.sv
// Pipelined right barrel shifter (LSR/ASR/ROR) with sticky output and valid/ready handshake.
module barrel_shifter_right_pipe
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned SHW = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] DIN,
  input  logic [SHW-1:0]   SEL,
  input  mode_t            MODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] DOUT,
  output logic             STICKY
);

  // Index k is the input of stage k; index SHW is the output register.
  logic [SHW:0][WIDTH-1:0] data_s;
  logic [SHW:0][SHW-1:0]   sel_s;
  mode_t [SHW:0]           mode_s;
  logic [SHW:0]            fill_s;
  logic [SHW:0]            sticky_s;
  logic [SHW:0]            valid_s;
  logic                    advance;

  assign data_s[0]   = DIN;
  assign sel_s[0]    = SEL;
  assign mode_s[0]   = MODE;
  assign fill_s[0]   = DIN[WIDTH-1];
  assign sticky_s[0] = 1'b0;
  assign valid_s[0]  = IN_VALID;

  // Global stall: only a held result at the output freezes the chain.
  assign advance  = !valid_s[SHW] || OUT_READY;
  assign IN_READY = advance || !RST_N;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage_right #(
      .WIDTH(WIDTH),
      .SHIFT(1 << k)
    ) u_stage (
      .clk_i   (CLK),
      .rst_ni  (RST_N),
      .en_i    (advance),
      .data_i  (data_s[k]),
      .sel_i   (sel_s[k]),
      .mode_i  (mode_s[k]),
      .fill_i  (fill_s[k]),
      .sticky_i(sticky_s[k]),
      .valid_i (valid_s[k]),
      .data_o  (data_s[k+1]),
      .sel_o   (sel_s[k+1]),
      .mode_o  (mode_s[k+1]),
      .fill_o  (fill_s[k+1]),
      .sticky_o(sticky_s[k+1]),
      .valid_o (valid_s[k+1])
    );
  end

  assign DOUT      = data_s[SHW];
  assign STICKY    = sticky_s[SHW];
  assign OUT_VALID = valid_s[SHW];

  // Side information past the last stage has no consumer.
  logic unused_tail;
  assign unused_tail = ^{sel_s[SHW], mode_s[SHW], fill_s[SHW]};

endmodule
